// File: rtl/stream_arbiter_pkg.sv
// Shared types and helpers for the packet-aware round-robin stream arbiter.
// The optional per-port packet counters are enabled by STREAM_ARBITER_STATS_EN.
package stream_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_e;

   localparam int STATS_CNT_W = 16;
   localparam int MAX_N       = 16;
   localparam int MAX_SW      = 4;

   // Scan upward from last_gnt+1, wrapping at n (not at a power of two).
   function automatic logic [MAX_SW-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                                 input logic [MAX_SW-1:0] last_gnt,
                                                 input int n);
      logic [MAX_SW-1:0] pick;
      logic              found;
      int                idx;
      pick  = '0;
      found = 1'b0;
      for (int i = 1; i <= MAX_N; i++) begin
         idx = (int'(last_gnt) + i) % n;
         if (i <= n && !found && req[idx]) begin
            pick  = MAX_SW'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/stream_rr_picker.sv
// Combinational next-grant selector: first requester after last_gnt, modulo N.
module stream_rr_picker
   import stream_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int SW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [SW-1:0] last_gnt_i,
   output logic [SW-1:0] gnt_o,
   output logic          gnt_valid_o
);

   assign gnt_o       = SW'(rr_pick(MAX_N'(req_i), MAX_SW'(last_gnt_i), N));
   assign gnt_valid_o = |req_i;

endmodule

// File: rtl/stream_arbiter_rr.sv
// Round-robin arbiter sharing one registered output stream between N packet sources.
// Define STREAM_ARBITER_STATS_EN to add per-port completed-packet counters (pkt_cnt_o).
module stream_arbiter_rr
   import stream_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 48,
   parameter int SW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N*DW-1:0] s_data_i,
   input  logic [N-1:0]    s_valid_i,
   input  logic [N-1:0]    s_last_i,
   output logic [N-1:0]    s_ready_o,
   output logic [DW-1:0]   m_data_o,
   output logic            m_valid_o,
   output logic            m_last_o,
   output logic [SW-1:0]   m_sel_o,
   input  logic            m_ready_i,
   output logic            busy_o
`ifdef STREAM_ARBITER_STATS_EN
   ,
   output logic [N*STATS_CNT_W-1:0] pkt_cnt_o
`endif
);

   state_e        state_q, state_d;
   logic [SW-1:0] grant_q, grant_d;
   logic [SW-1:0] last_gnt_q, last_gnt_d;
   logic [SW-1:0] m_sel_q, m_sel_d;
   logic [DW-1:0] m_data_q, m_data_d;
   logic          m_valid_q, m_valid_d;
   logic          m_last_q, m_last_d;

   logic [SW-1:0] pick;
   logic          pick_valid;
   logic [N-1:0]  s_ready;
   logic          accept;

   stream_rr_picker #(
      .N  (N),
      .SW (SW)
   ) u_picker (
      .req_i       (s_valid_i),
      .last_gnt_i  (last_gnt_q),
      .gnt_o       (pick),
      .gnt_valid_o (pick_valid)
   );

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_gnt_d = last_gnt_q;
      s_ready    = '0;
      accept     = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d    = pick;
               last_gnt_d = pick;
               state_d    = LOCK;
            end
         end
         LOCK: begin
            // The single output slot may refill in the same cycle it drains.
            s_ready[grant_q] = !m_valid_q || m_ready_i;
            accept           = s_valid_i[grant_q] && s_ready[grant_q];
            if (accept && s_last_i[grant_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      m_sel_d   = m_sel_q;
      if (accept) begin
         m_data_d  = s_data_i[DW*grant_q +: DW];
         m_last_d  = s_last_i[grant_q];
         m_sel_d   = grant_q;
         m_valid_d = 1'b1;
      end else if (m_ready_i) begin
         m_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         last_gnt_q <= SW'(N-1);
         m_data_q   <= '0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         m_sel_q    <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_gnt_q <= last_gnt_d;
         m_data_q   <= m_data_d;
         m_valid_q  <= m_valid_d;
         m_last_q   <= m_last_d;
         m_sel_q    <= m_sel_d;
      end
   end

   assign s_ready_o = s_ready;
   assign m_data_o  = m_data_q;
   assign m_valid_o = m_valid_q;
   assign m_last_o  = m_last_q;
   assign m_sel_o   = m_sel_q;
   assign busy_o    = (state_q == LOCK);

`ifdef STREAM_ARBITER_STATS_EN
   logic [N-1:0][STATS_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      for (int k = 0; k < N; k++) begin
         if (accept && s_last_i[k] && grant_q == SW'(k)) cnt_d[k] = cnt_q[k] + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign pkt_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_stream_arbiter_rr.sv
// Scoreboard bench for stream_arbiter_rr: per-port source queues feed the DUT,
// expected output beats are queued by each scenario in the predicted grant order.
module tb_stream_arbiter_rr;
   import stream_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int DW = 48;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N*DW-1:0] s_data_i = '0;
   logic [N-1:0]    s_valid_i = '0;
   logic [N-1:0]    s_last_i = '0;
   logic [N-1:0]    s_ready_o;
   logic [DW-1:0]   m_data_o;
   logic            m_valid_o;
   logic            m_last_o;
   logic [SW-1:0]   m_sel_o;
   logic            m_ready_i = 1'b1;
   logic            busy_o;
`ifdef STREAM_ARBITER_STATS_EN
   logic [N*STATS_CNT_W-1:0] pkt_cnt_o;
`endif

   stream_arbiter_rr #(.N(N), .DW(DW), .SW(SW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_data_i  (s_data_i),
      .s_valid_i (s_valid_i),
      .s_last_i  (s_last_i),
      .s_ready_o (s_ready_o),
      .m_data_o  (m_data_o),
      .m_valid_o (m_valid_o),
      .m_last_o  (m_last_o),
      .m_sel_o   (m_sel_o),
      .m_ready_i (m_ready_i),
      .busy_o    (busy_o)
`ifdef STREAM_ARBITER_STATS_EN
      ,
      .pkt_cnt_o (pkt_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct packed {
      logic [SW-1:0] sel;
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   beat_t src_q[N][$];
   exp_t  exp_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   bit    xfer[N];

   // Source drivers and output monitor: handshakes are judged at the negedge,
   // queues advance and inputs change just after the following posedge.
   always begin
      exp_t e;
      @(negedge clk);
      for (int k = 0; k < N; k++) xfer[k] = rst_n && s_valid_i[k] && s_ready_o[k];
      if (rst_n && m_valid_o && m_ready_i) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL out_beat: got sel=%0d data=%h last=%0d, required no beat", m_sel_o, m_data_o, m_last_o);
         end else begin
            e = exp_q.pop_front();
            if ({m_sel_o, m_data_o, m_last_o} !== {e.sel, e.data, e.last}) begin
               n_err++;
               $display("FAIL out_beat: got sel=%0d data=%h last=%0d, required sel=%0d data=%h last=%0d",
                        m_sel_o, m_data_o, m_last_o, e.sel, e.data, e.last);
            end
         end
      end
      if (rst_n && m_valid_o && !m_ready_i) begin
         n_vec++;
         if (s_ready_o !== '0) begin
            n_err++;
            $display("FAIL stall_ready: got s_ready=%b, required 0000", s_ready_o);
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         if (xfer[k] && src_q[k].size() > 0) src_q[k].delete(0);
         xfer[k] = 1'b0;
         if (src_q[k].size() > 0) begin
            s_valid_i[k]          = 1'b1;
            s_data_i[DW*k +: DW]  = src_q[k][0].data;
            s_last_i[k]           = src_q[k][0].last;
         end else begin
            s_valid_i[k]          = 1'b0;
            s_data_i[DW*k +: DW]  = '0;
            s_last_i[k]           = 1'b0;
         end
      end
   end

   task automatic push_src(input int p, input int nb, input logic [DW-1:0] base);
      beat_t b;
      for (int i = 0; i < nb; i++) begin
         b.data = base + DW'(i);
         b.last = (i == nb - 1);
         src_q[p].push_back(b);
      end
   endtask

   task automatic push_exp(input int p, input int nb, input logic [DW-1:0] base);
      exp_t e;
      for (int i = 0; i < nb; i++) begin
         e.sel  = SW'(p);
         e.data = base + DW'(i);
         e.last = (i == nb - 1);
         exp_q.push_back(e);
      end
   endtask

   function automatic bit all_idle();
      bit r;
      r = (exp_q.size() == 0) && !m_valid_o;
      for (int k = 0; k < N; k++) if (src_q[k].size() != 0) r = 1'b0;
      return r;
   endfunction

   task automatic wait_drain(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (all_idle()) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n     = 1'b0;
      m_ready_i = 1'b1;
      for (int k = 0; k < N; k++) src_q[k].delete();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #12;
      n_vec++;
      if ({m_valid_o, m_last_o, busy_o} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_flags: got valid/last/busy=%b, required 000", {m_valid_o, m_last_o, busy_o});
      end
      n_vec++;
      if ({m_data_o, m_sel_o, s_ready_o} !== '0) begin
         n_err++;
         $display("FAIL reset_data: got data=%h sel=%0d ready=%b, required all 0", m_data_o, m_sel_o, s_ready_o);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({busy_o, m_valid_o} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_idle: got busy/valid=%b, required 00", {busy_o, m_valid_o});
      end
   endtask

   task automatic test_single_port();
      bit ok;
      do_reset();
      @(negedge clk);
      push_src(2, 3, 48'hA);
      push_exp(2, 3, 48'hA);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_vec++;
         if (c == 0 && {busy_o, m_valid_o} !== 2'b00) begin
            n_err++;
            $display("FAIL lat_c0: got busy/valid=%b, required 00", {busy_o, m_valid_o});
         end else if (c == 1 && {busy_o, s_ready_o, m_valid_o} !== {1'b1, 4'b0100, 1'b0}) begin
            n_err++;
            $display("FAIL lat_c1: got busy=%0d ready=%b valid=%0d, required 1 0100 0", busy_o, s_ready_o, m_valid_o);
         end else if (c >= 2 && c <= 4 &&
                      {m_valid_o, m_sel_o, m_data_o, m_last_o} !== {1'b1, 2'd2, DW'(48'hA + c - 2), (c == 4)}) begin
            n_err++;
            $display("FAIL lat_c%0d: got valid=%0d sel=%0d data=%h last=%0d, required 1 2 %h %0d",
                     c, m_valid_o, m_sel_o, m_data_o, m_last_o, DW'(48'hA + c - 2), (c == 4));
         end else if (c == 5 && {busy_o, m_valid_o} !== 2'b00) begin
            n_err++;
            $display("FAIL lat_c5: got busy/valid=%b, required 00", {busy_o, m_valid_o});
         end
      end
      wait_drain(20, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL single_drain: got timeout, required drained"); end
   endtask

   task automatic test_fairness();
      int out_cyc[$];
      bit ok;
      do_reset();
      @(negedge clk);
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < N; p++) begin
            push_src(p, 1, DW'(16 * r + p + 48'h100));
            push_exp(p, 1, DW'(16 * r + p + 48'h100));
         end
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (m_valid_o) out_cyc.push_back(c);
      end
      n_vec++;
      if (out_cyc.size() != 8) begin
         n_err++;
         $display("FAIL fair_count: got %0d output cycles, required 8", out_cyc.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (out_cyc[i] != 2 + 2 * i) begin
               n_err++;
               $display("FAIL fair_bubble%0d: got cycle %0d, required %0d", i, out_cyc[i], 2 + 2 * i);
            end
         end
      end
      wait_drain(20, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL fair_drain: got timeout, required drained"); end
   endtask

   task automatic test_lock_hold();
      bit ok;
      bit seen;
      do_reset();
      @(negedge clk);
      push_src(1, 4, 48'h1000);
      push_exp(1, 4, 48'h1000);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = busy_o;
      end
      n_vec++;
      if (!seen) begin n_err++; $display("FAIL lock_busy: got busy=0, required 1"); end
      push_src(0, 1, 48'h2000);
      push_src(2, 1, 48'h3000);
      push_exp(2, 1, 48'h3000);
      push_exp(0, 1, 48'h2000);
      wait_drain(40, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL lock_drain1: got timeout, required drained"); end
      @(negedge clk);
      push_src(1, 2, 48'h4000);
      push_exp(1, 2, 48'h4000);
      @(negedge clk);
      push_src(0, 1, 48'h5000);
      push_exp(0, 1, 48'h5000);
      wait_drain(40, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL lock_drain2: got timeout, required drained"); end
   endtask

   task automatic test_backpressure();
      bit done;
      do_reset();
      @(negedge clk);
      push_src(0, 5, 48'h7700);
      push_exp(0, 5, 48'h7700);
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(posedge clk);
         #1;
         m_ready_i = ~m_ready_i;
         done = all_idle();
      end
      m_ready_i = 1'b1;
      n_vec++;
      if (!done) begin n_err++; $display("FAIL bp_drain: got timeout, required 5 beats drained"); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit mid;
      do_reset();
      @(negedge clk);
      push_src(3, 6, 48'h3300);
      push_exp(3, 6, 48'h3300);
      mid = 1'b0;
      for (int i = 0; i < 20 && !mid; i++) begin
         @(negedge clk);
         mid = (exp_q.size() <= 4);
      end
      n_vec++;
      if (!mid) begin n_err++; $display("FAIL rmid_start: got no output, required 2 beats"); end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({m_valid_o, busy_o, m_data_o} !== '0) begin
         n_err++;
         $display("FAIL rmid_async: got valid=%0d busy=%0d data=%h, required 0 0 0", m_valid_o, busy_o, m_data_o);
      end
      for (int k = 0; k < N; k++) src_q[k].delete();
      exp_q.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      push_src(0, 1, 48'h0A0);
      push_src(3, 1, 48'h0A3);
      push_exp(0, 1, 48'h0A0);
      push_exp(3, 1, 48'h0A3);
      wait_drain(30, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL rmid_drain: got timeout, required drained"); end
   endtask

`ifdef STREAM_ARBITER_STATS_EN
   task automatic test_stats();
      bit ok;
      logic [STATS_CNT_W-1:0] want[N];
      do_reset();
      @(negedge clk);
      for (int i = 0; i < 5; i++) push_src(1, 2, DW'(48'h100 * i));
      for (int i = 0; i < 2; i++) push_src(3, 1, DW'(48'h900 + i));
      push_exp(1, 2, 48'h000);
      push_exp(3, 1, 48'h900);
      push_exp(1, 2, 48'h100);
      push_exp(3, 1, 48'h901);
      push_exp(1, 2, 48'h200);
      push_exp(1, 2, 48'h300);
      push_exp(1, 2, 48'h400);
      wait_drain(80, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL stats_drain: got timeout, required drained"); end
      want = '{16'd0, 16'd5, 16'd0, 16'd2};
      for (int k = 0; k < N; k++) begin
         n_vec++;
         if (pkt_cnt_o[STATS_CNT_W*k +: STATS_CNT_W] !== want[k]) begin
            n_err++;
            $display("FAIL stats_lane%0d: got %0d, required %0d", k, pkt_cnt_o[STATS_CNT_W*k +: STATS_CNT_W], want[k]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_port();
      test_fairness();
      test_lock_hold();
      test_backpressure();
      test_reset_mid();
`ifdef STREAM_ARBITER_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation timeout, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
